// File: rtl/fifo_read_drain.sv
// Read-domain drain engine for the async FIFO: pops a programmed number of words, forwards
// them through a 2-entry output buffer and checks them against an incrementing pattern.
module fifo_read_drain #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned LEN_WIDTH  = 16
) (
   input  logic                  rclk,
   input  logic                  rrst,
   input  logic                  start,
   input  logic [LEN_WIDTH-1:0]  len,
   input  logic [DATA_WIDTH-1:0] seed,
   input  logic                  rempty,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic                  rinc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  busy,
   output logic                  done,
   output logic [LEN_WIDTH-1:0]  rd_count,
   output logic [LEN_WIDTH-1:0]  err_count,
   output logic                  err_flag
);

   localparam logic [LEN_WIDTH-1:0]  LenOne  = LEN_WIDTH'(1);
   localparam logic [DATA_WIDTH-1:0] DataOne = DATA_WIDTH'(1);

   typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

   state_e                state_q;
   logic [LEN_WIDTH-1:0]  remaining_q;
   logic [LEN_WIDTH-1:0]  rd_count_q;
   logic [LEN_WIDTH-1:0]  err_count_q;
   logic [DATA_WIDTH-1:0] expected_q;
   logic                  err_flag_q;

   // Output buffer: buf0_q is always the head entry.
   logic [DATA_WIDTH-1:0] buf0_q;
   logic [DATA_WIDTH-1:0] buf1_q;
   logic [1:0]            count_q;

   logic buf_pop;
   logic buf_push;
   logic mismatch;
   logic buf_empty_next;

   always_comb begin
      buf_pop  = (count_q != 2'd0) && out_ready;
      // A full buffer may still accept a pop when its head leaves on the same edge.
      rinc     = (state_q == StRead) && !rempty && (remaining_q != '0) &&
                 ((count_q != 2'd2) || out_ready);
      buf_push = rinc;
      mismatch = (rdata != expected_q);
      buf_empty_next = (count_q == 2'd0) ||
                       ((count_q == 2'd1) && buf_pop && !buf_push);
   end

   always_ff @(posedge rclk) begin
      if (rrst) begin
         buf0_q  <= '0;
         buf1_q  <= '0;
         count_q <= 2'd0;
      end else begin
         case ({buf_push, buf_pop})
            2'b10: begin
               if (count_q == 2'd0) begin
                  buf0_q <= rdata;
               end else begin
                  buf1_q <= rdata;
               end
               count_q <= count_q + 2'd1;
            end
            2'b01: begin
               buf0_q  <= buf1_q;
               count_q <= count_q - 2'd1;
            end
            2'b11: begin
               if (count_q == 2'd1) begin
                  buf0_q <= rdata;
               end else begin
                  buf0_q <= buf1_q;
                  buf1_q <= rdata;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge rclk) begin
      if (rrst) begin
         state_q     <= StIdle;
         remaining_q <= '0;
         expected_q  <= '0;
         rd_count_q  <= '0;
         err_count_q <= '0;
         err_flag_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  remaining_q <= len;
                  expected_q  <= seed;
                  rd_count_q  <= '0;
                  err_count_q <= '0;
                  err_flag_q  <= 1'b0;
                  state_q     <= (len == '0) ? StDone : StRead;
               end
            end
            StRead: begin
               if (rinc) begin
                  remaining_q <= remaining_q - LenOne;
                  rd_count_q  <= rd_count_q + LenOne;
                  expected_q  <= expected_q + DataOne;
                  if (mismatch) begin
                     err_flag_q <= 1'b1;
                     if (err_count_q != '1) begin
                        err_count_q <= err_count_q + LenOne;
                     end
                  end
                  if (remaining_q == LenOne) begin
                     state_q <= StDrain;
                  end
               end
            end
            StDrain: begin
               if (buf_empty_next) begin
                  state_q <= StDone;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign out_valid = (count_q != 2'd0);
   assign out_data  = buf0_q;
   assign busy      = (state_q != StIdle);
   assign done      = (state_q == StDone);
   assign rd_count  = rd_count_q;
   assign err_count = err_count_q;
   assign err_flag  = err_flag_q;

endmodule

// File: tb/tb_fifo_read_drain.sv
// Directed bench for fifo_read_drain: a queue models the FIFO, vectors cover the main runs,
// hand sequences cover len=0 and reset mid-run.
module tb_fifo_read_drain;

   localparam int DW = 8;
   localparam int LW = 16;

   logic          rclk = 1'b0;
   logic          rrst;
   logic          start;
   logic [LW-1:0] len;
   logic [DW-1:0] seed;
   logic          rempty;
   logic [DW-1:0] rdata;
   logic          rinc;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          busy;
   logic          done;
   logic [LW-1:0] rd_count;
   logic [LW-1:0] err_count;
   logic          err_flag;

   fifo_read_drain #(
      .DATA_WIDTH(DW),
      .LEN_WIDTH (LW)
   ) dut (
      .rclk     (rclk),
      .rrst     (rrst),
      .start    (start),
      .len      (len),
      .seed     (seed),
      .rempty   (rempty),
      .rdata    (rdata),
      .rinc     (rinc),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .busy     (busy),
      .done     (done),
      .rd_count (rd_count),
      .err_count(err_count),
      .err_flag (err_flag)
   );

   always #5 rclk = ~rclk;

   typedef struct {
      string      name;
      int         len;
      logic [7:0] seed;
      logic [7:0] data[8];
      int         stall_after;
      int         stall_cycles;
      int         rdy_low;
      int         mid_start;
      int         exp_err;
      int         exp_low_pops;
      bit         timing;
   } vec_t;

   vec_t vecs[5];

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] fq[$];
   logic [DW-1:0] got[$];
   int            popped;
   int            cyc;
   int            empty_pop_viol;

   logic          nx_rst;
   logic          nx_start;
   logic          nx_ready;
   logic          nx_stall;
   logic [LW-1:0] nx_len;
   logic [DW-1:0] nx_seed;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock cycle: inputs applied at negedge, outputs sampled 1 time unit later.
   task automatic tick();
      logic [DW-1:0] tmp;
      @(negedge rclk);
      rrst      = nx_rst;
      start     = nx_start;
      len       = nx_len;
      seed      = nx_seed;
      out_ready = nx_ready;
      rempty    = nx_stall || (fq.size() == 0);
      rdata     = (fq.size() != 0) ? fq[0] : '0;
      #1;
      if (rinc) begin
         if (rempty) begin
            empty_pop_viol++;
         end else begin
            tmp = fq.pop_front();
            popped++;
         end
      end
      if (out_valid && out_ready && !rrst) got.push_back(out_data);
      cyc++;
   endtask

   task automatic set_vec(input int i, input string nm, input int ln, input logic [7:0] sd,
                          input int sa, input int sc, input int rl, input int ms,
                          input int ee, input int elp, input bit tm);
      vecs[i].name         = nm;
      vecs[i].len          = ln;
      vecs[i].seed         = sd;
      vecs[i].stall_after  = sa;
      vecs[i].stall_cycles = sc;
      vecs[i].rdy_low      = rl;
      vecs[i].mid_start    = ms;
      vecs[i].exp_err      = ee;
      vecs[i].exp_low_pops = elp;
      vecs[i].timing       = tm;
   endtask

   task automatic run_vec(input vec_t v);
      int c;
      int stall_cnt;
      int held_bad;
      int low_pops;
      int first_rinc;
      int last_rinc;
      int nrinc;
      int first_acc;
      int last_acc;
      int done_cyc;
      fq.delete();
      got.delete();
      for (int i = 0; i < v.len; i++) fq.push_back(v.data[i]);
      fq.push_back(8'hA5);
      fq.push_back(8'h5A);
      popped = 0; empty_pop_viol = 0; cyc = 0;
      stall_cnt = 0; held_bad = 0; low_pops = -1;
      first_rinc = -1; last_rinc = -1; nrinc = 0;
      first_acc = -1; last_acc = -1; done_cyc = -1;

      nx_len   = LW'(v.len);
      nx_seed  = v.seed;
      nx_start = 1'b1;
      nx_ready = (v.rdy_low == 0);
      nx_stall = 1'b0;
      tick();
      nx_start = 1'b0;
      nx_len   = 16'h00FF;
      nx_seed  = 8'h77;

      while (done_cyc < 0 && cyc < 200) begin
         c = cyc;
         nx_ready = (c >= v.rdy_low);
         if (v.rdy_low > 0 && c == v.rdy_low) low_pops = popped;
         nx_start = (v.mid_start != 0 && c == v.mid_start);
         if (nx_start) begin
            nx_len  = 16'd7;
            nx_seed = 8'h99;
         end
         nx_stall = (v.stall_cycles > 0 && popped == v.stall_after &&
                     stall_cnt < v.stall_cycles);
         if (nx_stall) stall_cnt++;
         tick();
         if (rinc) begin
            nrinc++;
            if (first_rinc < 0) first_rinc = c;
            last_rinc = c;
         end
         if (out_valid && !out_ready && out_data !== v.data[0]) held_bad++;
         if (out_valid && out_ready) begin
            if (first_acc < 0) first_acc = c;
            last_acc = c;
         end
         if (done) begin
            done_cyc = c;
            check({v.name, " busy_at_done"}, 32'(busy), 1);
         end
      end
      nx_start = 1'b0;

      check({v.name, " done_seen"}, 32'(done_cyc >= 0), 1);
      check({v.name, " rd_count"}, 32'(rd_count), v.len);
      check({v.name, " err_count"}, 32'(err_count), v.exp_err);
      check({v.name, " err_flag"}, 32'(err_flag), 32'(v.exp_err != 0));
      check({v.name, " pops"}, popped, v.len);
      check({v.name, " pop_on_empty"}, empty_pop_viol, 0);
      check({v.name, " words_out"}, got.size(), v.len);
      for (int i = 0; i < v.len && i < got.size(); i++) begin
         check($sformatf("%s word%0d", v.name, i), 32'(got[i]), 32'(v.data[i]));
      end
      if (v.rdy_low > 0) begin
         check({v.name, " pops_while_blocked"}, low_pops, v.exp_low_pops);
         check({v.name, " head_held"}, held_bad, 0);
      end
      if (v.timing) begin
         check({v.name, " first_rinc_cyc"}, first_rinc, 1);
         check({v.name, " last_rinc_cyc"}, last_rinc, v.len);
         check({v.name, " rinc_cycles"}, nrinc, v.len);
         check({v.name, " first_out_cyc"}, first_acc, 2);
         check({v.name, " last_out_cyc"}, last_acc, v.len + 1);
         check({v.name, " done_cyc"}, done_cyc, v.len + 2);
      end
      tick();
      check({v.name, " done_pulse"}, 32'(done), 0);
      check({v.name, " idle_after"}, 32'(busy), 0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " rinc"}, 32'(rinc), 0);
      check({tag, " out_valid"}, 32'(out_valid), 0);
      check({tag, " out_data"}, 32'(out_data), 0);
      check({tag, " busy"}, 32'(busy), 0);
      check({tag, " done"}, 32'(done), 0);
      check({tag, " rd_count"}, 32'(rd_count), 0);
      check({tag, " err_count"}, 32'(err_count), 0);
      check({tag, " err_flag"}, 32'(err_flag), 0);
   endtask

   initial begin
      int rinc_seen;
      rrst = 1'b1; start = 1'b0; len = '0; seed = '0;
      rempty = 1'b1; rdata = '0; out_ready = 1'b1;
      nx_rst = 1'b1; nx_start = 1'b0; nx_ready = 1'b1; nx_stall = 1'b0;
      nx_len = '0; nx_seed = '0;
      popped = 0; cyc = 0; empty_pop_viol = 0;

      set_vec(0, "stream", 5, 8'h10, 0, 0, 0, 0, 0, 0, 1'b1);
      vecs[0].data = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h00, 8'h00, 8'h00};
      set_vec(1, "stall", 4, 8'h20, 2, 3, 0, 0, 0, 0, 1'b0);
      vecs[1].data = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h00, 8'h00, 8'h00, 8'h00};
      set_vec(2, "backpressure", 6, 8'h30, 0, 0, 5, 0, 0, 2, 1'b0);
      vecs[2].data = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h00, 8'h00};
      set_vec(3, "mismatch_wrap", 4, 8'hFE, 0, 0, 0, 0, 1, 0, 1'b0);
      vecs[3].data = '{8'hFE, 8'hFF, 8'h05, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
      set_vec(4, "start_busy", 3, 8'h40, 0, 0, 0, 2, 0, 0, 1'b0);
      vecs[4].data = '{8'h40, 8'h41, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

      fq.push_back(8'h11);
      repeat (3) tick();
      check_reset_values("reset");
      nx_rst = 1'b0;
      tick();

      for (int i = 0; i < 5; i++) run_vec(vecs[i]);

      // len=0: done the cycle after start, never a pop.
      fq.delete();
      fq.push_back(8'h11);
      rinc_seen = 0;
      nx_len = '0; nx_seed = 8'h00; nx_start = 1'b1;
      tick();
      if (rinc) rinc_seen++;
      nx_start = 1'b0;
      tick();
      if (rinc) rinc_seen++;
      check("len0 done", 32'(done), 1);
      check("len0 busy", 32'(busy), 1);
      tick();
      if (rinc) rinc_seen++;
      check("len0 done_pulse", 32'(done), 0);
      check("len0 idle", 32'(busy), 0);
      check("len0 no_rinc", rinc_seen, 0);
      check("len0 rd_count", 32'(rd_count), 0);

      // Reset after 2 of 8 pops.
      fq.delete();
      for (int i = 0; i < 8; i++) fq.push_back(8'(8'h50 + i));
      for (int i = 0; i < 6; i++) fq.push_back(8'hC0);
      popped = 0; cyc = 0;
      nx_len = 16'd8; nx_seed = 8'h50; nx_start = 1'b1; nx_ready = 1'b1;
      tick();
      nx_start = 1'b0;
      while (popped < 2 && cyc < 20) tick();
      check("rstmid reached_2_pops", popped, 2);
      nx_rst = 1'b1;
      tick();
      nx_rst = 1'b0;
      tick();
      check_reset_values("rstmid");
      rinc_seen = 0;
      repeat (4) begin
         tick();
         if (rinc) rinc_seen++;
      end
      check("rstmid no_rinc_until_start", rinc_seen, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_read_drain.md
# fifo_read_drain

Read-side consumer for the asynchronous FIFO, living entirely in the read clock domain. On a start command it pops a programmed number of words from the FIFO, never popping while the FIFO is empty. It forwards each word on a valid/ready output stream through a 2-entry buffer and checks it against an incrementing reference pattern. It is the reader counterpart to the write-side traffic that fills the FIFO, and it serves as both a bring-up drain engine and a data-integrity checker.

## Interface
- DATA_WIDTH, 8, FIFO word width
- LEN_WIDTH, 16, width of length and counters
- rclk  in  1  read clock; all logic on rising edge
- rrst  in  1  synchronous, active-high reset
- start  in  1  1-cycle command; sampled only in IDLE
- len  in  LEN_WIDTH  words to pop; sampled with start
- seed  in  DATA_WIDTH  expected value of first word; sampled with start
- rempty  in  1  FIFO empty flag
- rdata  in  DATA_WIDTH  FIFO head word, valid whenever rempty=0
- rinc  out  1  FIFO pop strobe
- out_valid  out  1  output word available
- out_ready  in  1  downstream accepts the word when out_valid=1
- out_data  out  DATA_WIDTH  output word
- busy  out  1  state is not IDLE
- done  out  1  1-cycle pulse on completion
- rd_count  out  LEN_WIDTH  words popped in the current or last run
- err_count  out  LEN_WIDTH  mismatches, saturating at all-ones
- err_flag  out  1  sticky; set on first mismatch, cleared by start or rrst

## Operation
- States: IDLE, READ, DRAIN, DONE.
- IDLE on start:
  - load remaining=len and expected=seed.
  - Clear rd_count, err_count and err_flag.
  - If len=0, go to DONE; otherwise go to READ.
- READ: rinc = !rempty && remaining!=0 && buffer entries<2, with one exception: when buffer is full and out_ready=1 this cycle, popping is allowed because an entry frees the same edge.
- Each pop, at the same edge:
  - write rdata into the buffer tail.
  - Decrement remaining and increment rd_count.
  - Compare rdata with expected. On mismatch, increment err_count (saturating) and set err_flag.
  - Increment expected mod 2^DATA_WIDTH.
- READ -> DRAIN when the final pop occurs (remaining goes 1->0).
- DRAIN -> DONE when the buffer is empty.
- DONE: assert done for one cycle, then go to IDLE.
- rinc is combinational from state, rempty, buffer occupancy and out_ready. It is never 1 when rempty=1 or when the state is not READ.
- Buffer: 2-entry FIFO, registered outputs.
  - out_valid = (entries!=0); out_data = head entry.
  - A pop from the buffer occurs when out_valid && out_ready.
  - Simultaneous push and pop keep occupancy unchanged.
- start while busy is ignored; len, seed and the counters are not disturbed.
- Word arithmetic: expected wraps 0xFF -> 0x00 for DATA_WIDTH=8. rd_count never exceeds len.

## Timing
- Reset values (rrst=1 at an edge, in any state):
  - state=IDLE, buffer empty.
  - rinc=0, out_valid=0, out_data=0, busy=0, done=0.
  - rd_count=0, err_count=0, err_flag=0.
- Reset mid-run abandons the run; words already popped are lost.
- Start to first rinc: start sampled at edge N, so rinc can be 1 in cycle N+1 if rempty=0.
- Pop to output: a word popped at edge M appears with out_valid=1 in cycle M+1. Latency is 1 cycle with an empty buffer.
- Throughput: 1 word/cycle when rempty=0 and out_ready=1 continuously.
- done is asserted in the cycle after DRAIN sees the buffer empty. For len=0 it is asserted in the cycle after start.
- busy=1 from the cycle after start through the done cycle, inclusive.
- rempty rising mid-run: rinc drops the same cycle, the state stays READ, and popping resumes when rempty falls.
- out_ready low with 2 words buffered: rinc=0 regardless of rempty, and out_data stays stable until accepted.

## Test plan
- Streaming run:
  - stimulus: start with len=5, seed=0x10; FIFO holds 0x10..0x14; out_ready=1.
  - response: rinc high for 5 consecutive cycles; out_data 0x10..0x14 on consecutive cycles; done 1 cycle after the last output; rd_count=5, err_count=0.
- Empty stall:
  - stimulus: len=4; rempty=1 for 3 cycles after the 2nd pop.
  - response: rinc=0 while rempty=1; no extra pops; all 4 words delivered in order.
- Backpressure:
  - stimulus: len=6, out_ready=0 for 5 cycles from start.
  - response: exactly 2 pops, then rinc=0; out_data holds the first word; after release, all 6 words arrive in order.
- Mismatch and wrap:
  - stimulus: seed=0xFE; data 0xFE, 0xFF, 0x05, 0x01.
  - response: err_count=1, err_flag=1, expected wraps to 0x00 and 0x01 matches; rd_count=4.
- len=0 and start while busy:
  - stimulus: len=0 start; then len=3 start followed by a second start mid-run.
  - response: len=0 gives done 1 cycle after start with no rinc; the mid-run start is ignored and rd_count=3.
- Reset mid-run:
  - stimulus: rrst=1 for 1 cycle after 2 of 8 pops.
  - response: all outputs return to reset values next cycle; rinc=0 until a new start.
